// File: rtl/rotator_pkg.sv
// Shared mode and direction encodings for the pattern rotator family.
package rotator_pkg;

    localparam logic [1:0] MODE_ROT    = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/tick_div.sv
// Programmable prescaler: asserts tick_c on the enabled cycle where cnt reaches step_div.
module tick_div #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [DIV_W-1:0] step_div,
    output logic [DIV_W-1:0] cnt,
    output logic             tick_c
);

    logic due_c;

    // >= so a step_div shrunk below the running count fires on the next enabled cycle
    assign due_c  = (cnt >= step_div);
    assign tick_c = en && !clear && due_c;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            if (due_c) cnt <= '0;
            else       cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/rotator_n.sv
// WIDTH-bit pattern register stepped by a prescaler in rotate, shift, bounce or hold mode.
module rotator_n
    import rotator_pkg::*;
#(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      DIV_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             direction,
    input  logic [1:0]       mode,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load,
    input  logic [DIV_W-1:0] step_div,
    output logic [WIDTH-1:0] out,
    output logic             step,
    output logic             wrap,
    output logic             dir_cur
);

    logic             tick_c;
    logic [DIV_W-1:0] cnt;
    logic [WIDTH-1:0] nxt_out;
    logic             nxt_wrap;
    logic             nxt_dir;

    tick_div #(.DIV_W(DIV_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clear    (load_en),
        .step_div (step_div),
        .cnt      (cnt),
        .tick_c   (tick_c)
    );

    // Next pattern, end-bit event and effective direction for a tick this cycle
    always_comb begin
        nxt_out  = out;
        nxt_wrap = 1'b0;
        nxt_dir  = (mode == MODE_BOUNCE) ? dir_cur : direction;
        case (mode)
            MODE_ROT: begin
                if (direction == DIR_LEFT) begin
                    nxt_out  = {out[WIDTH-2:0], out[WIDTH-1]};
                    nxt_wrap = out[WIDTH-1];
                end else begin
                    nxt_out  = {out[0], out[WIDTH-1:1]};
                    nxt_wrap = out[0];
                end
            end
            MODE_SHIFT: begin
                if (direction == DIR_LEFT) begin
                    nxt_out  = {out[WIDTH-2:0], 1'b0};
                    nxt_wrap = out[WIDTH-1];
                end else begin
                    nxt_out  = {1'b0, out[WIDTH-1:1]};
                    nxt_wrap = out[0];
                end
            end
            MODE_BOUNCE: begin
                // An all-zero pattern has nothing to bounce off and stays put
                if (out != '0) begin
                    if ((dir_cur == DIR_LEFT && out[WIDTH-1]) ||
                        (dir_cur == DIR_RIGHT && out[0])) begin
                        nxt_dir  = ~dir_cur;
                        nxt_wrap = 1'b1;
                    end
                    if (nxt_dir == DIR_LEFT) nxt_out = {out[WIDTH-2:0], 1'b0};
                    else                     nxt_out = {1'b0, out[WIDTH-1:1]};
                end
            end
            default: begin
                nxt_out = out;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= RESET_VAL;
            step    <= 1'b0;
            wrap    <= 1'b0;
            dir_cur <= DIR_LEFT;
        end else if (load_en) begin
            out     <= load;
            step    <= 1'b0;
            wrap    <= 1'b0;
            dir_cur <= direction;
        end else begin
            step <= tick_c;
            wrap <= tick_c && nxt_wrap;
            if (tick_c) out <= nxt_out;
            // Bounce keeps its own direction; other modes track the input every cycle
            if (mode != MODE_BOUNCE || tick_c) dir_cur <= nxt_dir;
        end
    end

endmodule

// File: tb/tb_rotator_n.sv
// Directed self-checking bench for rotator_n (WIDTH=4, RESET_VAL=0001).
module tb_rotator_n;

    logic       clk;
    logic       rst;
    logic       en;
    logic       direction;
    logic [1:0] mode;
    logic       load_en;
    logic [3:0] load;
    logic [7:0] step_div;
    logic [3:0] out;
    logic       step;
    logic       wrap;
    logic       dir_cur;

    int tests;
    int fails;

    rotator_n #(.WIDTH(4), .DIV_W(8), .RESET_VAL(4'b0001)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .direction (direction),
        .mode      (mode),
        .load_en   (load_en),
        .load      (load),
        .step_div  (step_div),
        .out       (out),
        .step      (step),
        .wrap      (wrap),
        .dir_cur   (dir_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_out, input logic e_step,
                           input logic e_wrap, input logic e_dir);
        chk({tag, ".out"},  32'(out),     32'(e_out));
        chk({tag, ".step"}, 32'(step),    32'(e_step));
        chk({tag, ".wrap"}, 32'(wrap),    32'(e_wrap));
        chk({tag, ".dir"},  32'(dir_cur), 32'(e_dir));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; en = 1'b1; direction = 1'b1; mode = 2'b00;
        load_en = 1'b0; load = 4'b0000; step_div = 8'd0;

        // reset, and reset beating load
        cyc(); chk_all("rst", 4'b0001, 0, 0, 0);
        load_en = 1'b1; load = 4'b1111;
        cyc(); chk_all("rst_load", 4'b0001, 0, 0, 0);

        // rotate left
        rst = 1'b0; load_en = 1'b0; direction = 1'b0;
        cyc(); chk_all("rotl1", 4'b0010, 1, 0, 0);
        cyc(); chk_all("rotl2", 4'b0100, 1, 0, 0);
        cyc(); chk_all("rotl3", 4'b1000, 1, 0, 0);
        cyc(); chk_all("rotl4", 4'b0001, 1, 1, 0);

        // rotate right with wrap
        direction = 1'b1;
        cyc(); chk_all("rotr1", 4'b1000, 1, 1, 1);

        // step_div=2: tick every third enabled cycle
        step_div = 8'd2;
        cyc(); chk_all("div_a", 4'b1000, 0, 0, 1);
        cyc(); chk_all("div_b", 4'b1000, 0, 0, 1);
        cyc(); chk_all("div_c", 4'b0100, 1, 0, 1);

        // en low for two cycles mid-count stretches the period to five
        cyc(); chk_all("gap_a", 4'b0100, 0, 0, 1);
        en = 1'b0;
        cyc(); chk_all("gap_b", 4'b0100, 0, 0, 1);
        cyc(); chk_all("gap_c", 4'b0100, 0, 0, 1);
        en = 1'b1;
        cyc(); chk_all("gap_d", 4'b0100, 0, 0, 1);
        cyc(); chk_all("gap_e", 4'b0010, 1, 0, 1);

        // shrinking step_div mid-count ticks on the next cycle
        cyc(); chk_all("shr_a", 4'b0010, 0, 0, 1);
        step_div = 8'd0;
        cyc(); chk_all("shr_b", 4'b0001, 1, 0, 1);

        // bounce from a fresh load; direction input ignored after load
        mode = 2'b10; load_en = 1'b1; load = 4'b0001; direction = 1'b0;
        cyc(); chk_all("bld", 4'b0001, 0, 0, 0);
        load_en = 1'b0; direction = 1'b1;
        cyc(); chk_all("bnc1", 4'b0010, 1, 0, 0);
        cyc(); chk_all("bnc2", 4'b0100, 1, 0, 0);
        cyc(); chk_all("bnc3", 4'b1000, 1, 0, 0);
        cyc(); chk_all("bnc4", 4'b0100, 1, 1, 1);
        cyc(); chk_all("bnc5", 4'b0010, 1, 0, 1);
        cyc(); chk_all("bnc6", 4'b0001, 1, 0, 1);
        cyc(); chk_all("bnc7", 4'b0010, 1, 1, 0);

        // shift left with discards, zero is sticky
        mode = 2'b01; load_en = 1'b1; load = 4'b1001; direction = 1'b0;
        cyc(); chk_all("sld", 4'b1001, 0, 0, 0);
        load_en = 1'b0;
        cyc(); chk_all("shf1", 4'b0010, 1, 1, 0);
        cyc(); chk_all("shf2", 4'b0100, 1, 0, 0);
        cyc(); chk_all("shf3", 4'b1000, 1, 0, 0);
        cyc(); chk_all("shf4", 4'b0000, 1, 1, 0);
        cyc(); chk_all("shf5", 4'b0000, 1, 0, 0);

        // bounce on zero holds without flipping
        mode = 2'b10;
        cyc(); chk_all("bz1", 4'b0000, 1, 0, 0);
        cyc(); chk_all("bz2", 4'b0000, 1, 0, 0);

        // load wins over a due tick
        mode = 2'b00; load_en = 1'b1; load = 4'b0110; direction = 1'b1;
        cyc(); chk_all("ldtick", 4'b0110, 0, 0, 1);

        // hold: pattern fixed, step pulses, dir_cur tracks direction
        load_en = 1'b0; mode = 2'b11;
        cyc(); chk_all("hold1", 4'b0110, 1, 0, 1);
        direction = 1'b0;
        cyc(); chk_all("hold2", 4'b0110, 1, 0, 0);

        // reset mid-count discards the partial count
        mode = 2'b00; step_div = 8'd3;
        cyc(); chk_all("rmc_a", 4'b0110, 0, 0, 0);
        cyc(); chk_all("rmc_b", 4'b0110, 0, 0, 0);
        rst = 1'b1;
        cyc(); chk_all("rmc_rst", 4'b0001, 0, 0, 0);
        rst = 1'b0; step_div = 8'd1;
        cyc(); chk_all("rmc_c", 4'b0001, 0, 0, 0);
        cyc(); chk_all("rmc_d", 4'b0010, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
